// File: rtl/dmem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl_pkg
// Description : Shared encodings for the cpu54 data-memory access controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_ctrl_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_RD   = 3'd1;
    localparam state_t ST_WAIT = 3'd2;
    localparam state_t ST_WR   = 3'd3;
    localparam state_t ST_ERR  = 3'd4;
    localparam state_t ST_RESP = 3'd5;

endpackage : dmem_ctrl_pkg
`default_nettype wire

// File: rtl/dmem_lane_unit.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_unit
// Description : Little-endian lane select/extend for loads, lane merge for stores.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_unit
    import dmem_ctrl_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_sext,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_ld_value,
    output logic [31:0] o_st_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_off, 3'b000} +: 8];
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

        case (i_size)
            SZ_BYTE: o_ld_value = {{24{i_sext & w_byte[7]}}, w_byte};
            SZ_HALF: o_ld_value = {{16{i_sext & w_half[15]}}, w_half};
            default: o_ld_value = i_word;
        endcase

        // Only the addressed lane is replaced; the rest of the fetched word is kept.
        o_st_word = i_word;
        case (i_size)
            SZ_BYTE: o_st_word[{i_off, 3'b000} +: 8] = i_st_data[7:0];
            SZ_HALF: begin
                if (i_off[1]) o_st_word[31:16] = i_st_data[15:0];
                else          o_st_word[15:0]  = i_st_data[15:0];
            end
            default: o_st_word = i_st_data;
        endcase
    end

endmodule : dmem_lane_unit
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : cpu54 load/store port to dmem array controller with sub-word RMW.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          AW        = 11,
    parameter int          RD_LAT    = 1
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          sext,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          ready,
    output logic          err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rena,
    output logic          mem_wena,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int                 c_cnt_w    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(RD_LAT - 1);

    state_t              r_state;
    state_t              w_next_state;

    logic                r_we;
    logic [1:0]          r_size;
    logic                r_sext;
    logic [31:0]         r_wdata;
    logic [AW+1:0]       r_off;
    logic                r_err;
    logic [31:0]         r_word;
    logic [31:0]         r_rdata;
    logic [c_cnt_w-1:0]  r_wait_cnt;

    logic [31:0]         w_off;
    logic                w_accept;
    logic                w_acc_err;
    logic                w_wait_done;
    logic [31:0]         w_lane_word;
    logic [31:0]         w_ld_value;
    logic [31:0]         w_st_word;

    // Addresses below the base wrap to huge offsets and fail the window test.
    assign w_off     = addr - BASE_ADDR;
    assign w_accept  = (r_state == ST_IDLE) && req;
    assign w_acc_err = (size == SZ_RSVD)
                    || (w_off[31:AW+2] != '0)
                    || ((size == SZ_HALF) && w_off[0])
                    || ((size == SZ_WORD) && (w_off[1:0] != 2'b00));

    assign w_wait_done = (r_state == ST_WAIT) && (r_wait_cnt == c_cnt_last);
    assign w_lane_word = (r_state == ST_WAIT) ? mem_rdata : r_word;

    dmem_lane_unit u_lane (
        .i_word     (w_lane_word),
        .i_off      (r_off[1:0]),
        .i_size     (r_size),
        .i_sext     (r_sext),
        .i_st_data  (r_wdata),
        .o_ld_value (w_ld_value),
        .o_st_word  (w_st_word)
    );

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_acc_err)                   w_next_state = ST_ERR;
                    else if (we && (size == SZ_WORD)) w_next_state = ST_WR;
                    else                              w_next_state = ST_RD;
                end
            end
            ST_RD:   w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (w_wait_done) w_next_state = r_we ? ST_WR : ST_RESP;
            end
            ST_WR:   w_next_state = ST_RESP;
            ST_ERR:  w_next_state = ST_RESP;
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_rena  = 1'b0;
        mem_wena  = 1'b0;
        mem_wdata = '0;
        ready     = 1'b0;
        err       = 1'b0;
        case (r_state)
            ST_RD, ST_WAIT: mem_rena = 1'b1;
            ST_WR: begin
                mem_wena  = 1'b1;
                mem_wdata = w_st_word;
            end
            ST_RESP: begin
                ready = 1'b1;
                err   = r_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_we       <= 1'b0;
            r_size     <= '0;
            r_sext     <= 1'b0;
            r_wdata    <= '0;
            r_off      <= '0;
            r_err      <= 1'b0;
            r_word     <= '0;
            r_rdata    <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= we;
                r_size  <= size;
                r_sext  <= sext;
                r_wdata <= wdata;
                r_off   <= w_off[AW+1:0];
                r_err   <= w_acc_err;
            end

            if (r_state == ST_WAIT) r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
            else                    r_wait_cnt <= '0;

            // Word capture and load result share the edge that leaves WAIT.
            if (w_wait_done) begin
                r_word <= mem_rdata;
                if (!r_we) r_rdata <= w_ld_value;
            end
        end
    end

    assign mem_addr = r_off[AW+1:2];
    assign rdata    = r_rdata;

endmodule : dmem_ctrl
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Self-checking bench for dmem_ctrl with a reference memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

    localparam logic [31:0] c_base = 32'h1001_0000;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b1;
    logic        req    = 1'b0;
    logic        we     = 1'b0;
    logic [1:0]  size   = 2'd0;
    logic        sext   = 1'b0;
    logic [31:0] addr   = 32'h0;
    logic [31:0] wdata  = 32'h0;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic [10:0] mem_addr;
    logic        mem_rena;
    logic        mem_wena;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk_in = ~clk_in;

    dmem_ctrl #(
        .BASE_ADDR (c_base),
        .AW        (11),
        .RD_LAT    (1)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .size      (size),
        .sext      (sext),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_rena  (mem_rena),
        .mem_wena  (mem_wena),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous RAM with one cycle of read latency, preloadable from the bench.
    logic [31:0] ram [0:2047];
    logic        pl_en   = 1'b0;
    logic [10:0] pl_idx  = 11'd0;
    logic [31:0] pl_data = 32'h0;

    always @(posedge clk_in) begin
        if (pl_en)    ram[pl_idx]   <= pl_data;
        if (mem_wena) ram[mem_addr] <= mem_wdata;
        if (mem_rena) mem_rdata     <= ram[mem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Reference model state
    logic [31:0] model_mem [0:2047];
    logic [31:0] model_rdata   = 32'h0;
    int          exp_ready_cyc = -1;
    int          acc_cyc       = 0;
    logic        exp_err       = 1'b0;
    int          exp_rena      = 0;
    logic        exp_wr        = 1'b0;
    logic        exp_load_ok   = 1'b0;
    logic [10:0] exp_idx       = 11'd0;
    logic [31:0] exp_wdata     = 32'h0;
    logic [31:0] exp_ld        = 32'h0;
    int          rena_seen     = 0;
    int          wena_seen     = 0;
    int          last_lat      = -1;
    logic        last_err      = 1'b0;
    logic [10:0] last_waddr    = 11'd0;
    logic        cmp_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Derives the full expected outcome of the request currently on the inputs.
    task automatic expect_txn();
        logic [31:0] off;
        logic [31:0] w;
        logic [31:0] v;
        logic [31:0] mask;
        int          sh;
        int          lat;
        off     = addr - c_base;
        exp_err = (size == 2'd3) || (off >= 32'h0000_2000)
               || ((size == 2'd1) && off[0])
               || ((size == 2'd2) && (off[1:0] != 2'b00));
        exp_idx = off[12:2];
        w       = model_mem[exp_idx];
        if (exp_err)            lat = 2;
        else if (we)            lat = (size == 2'd2) ? 2 : 4;
        else                    lat = 3;
        acc_cyc       = cyc;
        exp_ready_cyc = cyc + lat;
        exp_rena      = (exp_err || (we && (size == 2'd2))) ? 0 : 2;
        exp_wr        = !exp_err && we;
        exp_load_ok   = !exp_err && !we;
        sh   = (size == 2'd0) ? 8 * int'(off[1:0]) : 16 * int'(off[1]);
        mask = (size == 2'd0) ? 32'h0000_00FF : (size == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        v    = (w >> sh) & mask;
        if (sext && (size == 2'd0) && v[7])  v = v | 32'hFFFF_FF00;
        if (sext && (size == 2'd1) && v[15]) v = v | 32'hFFFF_0000;
        exp_ld    = v;
        exp_wdata = (size == 2'd2) ? wdata : ((w & ~(mask << sh)) | ((wdata & mask) << sh));
        rena_seen = 0;
        wena_seen = 0;
    endtask

    always @(negedge clk_in) begin
        if (reset) begin
            chk("rst_rdata", rdata, 32'h0);
            chk("rst_ready", {31'b0, ready}, 32'h0);
            chk("rst_err", {31'b0, err}, 32'h0);
            chk("rst_rena", {31'b0, mem_rena}, 32'h0);
            chk("rst_wena", {31'b0, mem_wena}, 32'h0);
            chk("rst_addr", 32'(mem_addr), 32'h0);
            chk("rst_wdata", mem_wdata, 32'h0);
        end else begin
            chk("rena_wena_excl", {31'b0, mem_rena & mem_wena}, 32'h0);
            if (mem_rena) begin
                rena_seen++;
                chk("rd_addr", 32'(mem_addr), 32'(exp_idx));
            end
            if (mem_wena) begin
                wena_seen++;
                last_waddr = mem_addr;
                chk("wena_allowed", {31'b0, exp_wr}, 32'h1);
                chk("wr_addr", 32'(mem_addr), 32'(exp_idx));
                chk("wr_data", mem_wdata, exp_wdata);
            end
            cmp_rdy = (cyc == exp_ready_cyc);
            chk("ready", {31'b0, ready}, {31'b0, cmp_rdy});
            if (cmp_rdy) begin
                chk("err", {31'b0, err}, {31'b0, exp_err});
                chk("rena_cycles", rena_seen, exp_rena);
                chk("wena_pulses", wena_seen, exp_wr ? 1 : 0);
                last_lat = cyc - acc_cyc;
                last_err = err;
                if (exp_load_ok) model_rdata = exp_ld;
                if (exp_wr)      model_mem[exp_idx] = exp_wdata;
            end else begin
                chk("err_idle", {31'b0, err}, 32'h0);
            end
            chk("rdata", rdata, model_rdata);
        end
    end

    task automatic preload(input logic [10:0] idx, input logic [31:0] data);
        @(posedge clk_in); #1;
        pl_en          = 1'b1;
        pl_idx         = idx;
        pl_data        = data;
        model_mem[idx] = data;
        @(posedge clk_in); #1;
        pl_en = 1'b0;
    endtask

    task automatic run(input logic t_we, input logic [1:0] t_size, input logic t_sext,
                       input logic [31:0] t_addr, input logic [31:0] t_wdata);
        @(posedge clk_in); #1;
        we    = t_we;
        size  = t_size;
        sext  = t_sext;
        addr  = t_addr;
        wdata = t_wdata;
        req   = 1'b1;
        expect_txn();
        @(posedge clk_in); #1;
        req = 1'b0;
        while (cyc <= exp_ready_cyc) begin
            @(posedge clk_in); #1;
        end
    endtask

    logic [1:0]  err_size [0:4] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd2};
    logic [31:0] err_addr [0:4] = '{32'h1001_0002, 32'h1001_0001, 32'h1001_0000,
                                    32'h1001_2000, 32'h1000_FFFC};

    initial begin
        for (int i = 0; i < 2048; i++) model_mem[i] = 32'h0;
        preload(11'd4, 32'h1122_3344);
        preload(11'd1, 32'h8899_AABB);
        preload(11'd8, 32'h5566_7788);
        @(negedge clk_in); #1;
        reset = 1'b0;
        chk("lit_reset_rdata", rdata, 32'h0);
        chk("lit_reset_ready", {31'b0, ready}, 32'h0);

        run(1'b1, 2'd2, 1'b0, 32'h1001_0008, 32'hDEAD_BEEF);
        chk("lit_wst_lat", last_lat, 2);
        chk("lit_wst_addr", 32'(last_waddr), 32'd2);
        run(1'b0, 2'd2, 1'b0, 32'h1001_0008, 32'h0);
        chk("lit_wld_data", rdata, 32'hDEAD_BEEF);
        chk("lit_wld_lat", last_lat, 3);
        chk("lit_wld_err", {31'b0, last_err}, 32'h0);

        run(1'b1, 2'd0, 1'b0, 32'h1001_0011, 32'h0000_00AB);
        chk("lit_bst_lat", last_lat, 4);
        run(1'b0, 2'd2, 1'b0, 32'h1001_0010, 32'h0);
        chk("lit_merge", rdata, 32'h1122_AB44);

        run(1'b0, 2'd0, 1'b1, 32'h1001_0004, 32'h0);
        chk("lit_lb_sext", rdata, 32'hFFFF_FFBB);
        run(1'b0, 2'd0, 1'b0, 32'h1001_0004, 32'h0);
        chk("lit_lb_zext", rdata, 32'h0000_00BB);
        run(1'b0, 2'd1, 1'b1, 32'h1001_0006, 32'h0);
        chk("lit_lh_sext", rdata, 32'hFFFF_8899);
        chk("lit_lh_lat", last_lat, 3);

        for (int i = 0; i < 5; i++) begin
            run(1'b0, err_size[i], 1'b0, err_addr[i], 32'h0);
            chk("lit_err_lat", last_lat, 2);
            chk("lit_err_flag", {31'b0, last_err}, 32'h1);
            chk("lit_err_rdata", rdata, 32'hFFFF_8899);
        end

        // Reset lands in the WAIT cycle of a byte store.
        @(posedge clk_in); #1;
        we = 1'b1; size = 2'd0; sext = 1'b0; addr = 32'h1001_0020; wdata = 32'h0000_00EE;
        req = 1'b1;
        expect_txn();
        @(posedge clk_in); #1;
        req = 1'b0;
        @(posedge clk_in); #2;
        exp_ready_cyc = -1;
        exp_wr        = 1'b0;
        exp_load_ok   = 1'b0;
        model_rdata   = 32'h0;
        reset         = 1'b1;
        #1;
        chk("lit_midrst_rdata", rdata, 32'h0);
        chk("lit_midrst_ready", {31'b0, ready}, 32'h0);
        chk("lit_midrst_err", {31'b0, err}, 32'h0);
        chk("lit_midrst_rena", {31'b0, mem_rena}, 32'h0);
        chk("lit_midrst_wena", {31'b0, mem_wena}, 32'h0);
        chk("lit_midrst_addr", 32'(mem_addr), 32'h0);
        chk("lit_midrst_wdata", mem_wdata, 32'h0);
        @(posedge clk_in);
        @(negedge clk_in); #1;
        reset = 1'b0;
        run(1'b0, 2'd2, 1'b0, 32'h1001_0020, 32'h0);
        chk("lit_after_rst", rdata, 32'h5566_7788);

        // req held high across three loads; each acceptance waits for IDLE.
        @(posedge clk_in); #1;
        we = 1'b0; size = 2'd2; sext = 1'b0; addr = 32'h1001_0008; req = 1'b1;
        expect_txn();
        @(posedge clk_in); #1;
        size = 2'd0; addr = 32'h1001_0005;
        while (cyc <= exp_ready_cyc) begin @(posedge clk_in); #1; end
        chk("lit_hold1", rdata, 32'hDEAD_BEEF);
        expect_txn();
        @(posedge clk_in); #1;
        size = 2'd1; addr = 32'h1001_0004;
        while (cyc <= exp_ready_cyc) begin @(posedge clk_in); #1; end
        chk("lit_hold2", rdata, 32'h0000_00AA);
        expect_txn();
        @(posedge clk_in); #1;
        req = 1'b0;
        while (cyc <= exp_ready_cyc) begin @(posedge clk_in); #1; end
        chk("lit_hold3", rdata, 32'h0000_AABB);
        chk("lit_hold3_lat", last_lat, 3);

        run(1'b1, 2'd1, 1'b0, 32'h1001_0006, 32'h1234_CAFE);
        chk("lit_hst_lat", last_lat, 4);
        run(1'b0, 2'd2, 1'b0, 32'h1001_0004, 32'h0);
        chk("lit_hst_merge", rdata, 32'hCAFE_AABB);

        repeat (3) @(posedge clk_in);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

endmodule : tb_dmem_ctrl
`default_nettype wire
